wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Final (write-back) stage of the 5-stage in-order LoongArch pipeline; consumes the MEM-to-WB bus.
- Commits register-file writes, CSR writes, TLB maintenance commands and exception/ertn/refetch flushes.
- Provides a WB forwarding bus to ID and an optional debug-trace port.
- Retires at most one instruction per cycle; never stalls.

Parameters:
- MS2WS_BUS_LEN, 219, width of ms2ws_bus (field map below).
- EXC_DATA_LEN, 101, width of the exception/CSR sub-bus (low bits of ms2ws_bus).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ws_allowin  out  1  WB can accept; constant 1.
- ms2ws_valid  in  1  MEM presents a valid instruction.
- ms2ws_bus  in  219  MSB to LSB: exc_ecode[6], refetch[1], tlbsrch[1], tlbrd[1], tlbwr[1], tlbfill[1], srch_hit[1], srch_index[4], pc[32], gr_we[1], dest[5], result[32], rkd_value[32], exc_data[101].
  - exc_data MSB to LSB: csr_op[4] (reserved, ignored), vaddr[32], csr_we[1], csr_wmask[32], csr_num[14], ertn[1], ex[1], esubcode[9], ecode[6], csr_re[1].
- rf_we / rf_waddr / rf_wdata  out  1/5/32  register-file write port.
- wb_forward_zip  out  38  {rf_we, rf_waddr, rf_wdata} to ID.
- ws_csr_block  out  1  valid CSR read/write or ertn in WB (ID hazard).
- csr_re / csr_num  out  1/14  CSR read port.
- csr_rvalue  in  32  CSR read data, combinational.
- csr_we / csr_wmask / csr_wvalue  out  1/32/32  CSR write port.
- wb_ex / wb_ertn  out  1/1  exception / ertn commit to CSR file.
- wb_ecode / wb_esubcode / wb_pc / wb_vaddr  out  6/9/32/32  exception info.
- tlbsrch_we / tlbsrch_hit / tlbsrch_index  out  1/1/4  TLBSRCH commit.
- tlbrd_we / tlbwr_we / tlbfill_we  out  1 each  TLB command commit.
- ws_reflush  out  1  flush all earlier stages.
- refetch_flush / refetch_pc  out  1/32  post-TLB/CSR refetch redirect.

Behaviour:
- State: ws_valid register and a 219-bit bus register.
- Reset: ws_valid=0, bus register=0. All outputs are gated by ws_valid, so every output is 0 during and after reset; ws_allowin=1.
- Bus capture: bus register loads ms2ws_bus when ms2ws_valid is high. ws_valid <= ms2ws_valid every cycle.
- Flush rule: ws_valid <= 0 in the cycle after ws_reflush=1, even if ms2ws_valid=1 that cycle. Reset has priority over the flush rule.
- Exception: exc = ws_valid & (exc_ecode!=0 | ex).
  - wb_ecode = exc_ecode if nonzero, else ecode.
  - wb_esubcode = 0 if exc_ecode!=0, else esubcode.
  - wb_ex = exc. wb_pc = pc. wb_vaddr = vaddr.
- Commit gating: commit = ws_valid & ~exc.
  - rf_we = commit & gr_we & (dest!=0).
  - csr_we, tlb*_we and wb_ertn each require commit.
  - ertn and exc are mutually exclusive; exc wins.
- Write data: rf_wdata = csr_rvalue when csr_re, else result. csr_re = ws_valid & csr_re-field.
- CSR write: csr_num = csr_num-field; csr_wvalue = rkd_value; csr_wmask = csr_wmask-field.
- TLBSRCH: tlbsrch_we = commit & tlbsrch; tlbsrch_hit and tlbsrch_index pass through.
- Refetch: refetch_flush = commit & refetch; refetch_pc = pc + 4 (32-bit wrap: 0xFFFFFFFC gives 0).
- ws_reflush = wb_ex | wb_ertn | refetch_flush; a single-cycle pulse per instruction.
- ws_csr_block = ws_valid & (csr_re | csr_we | ertn).
- Latency: one cycle from MEM handoff to commit. Back-to-back instructions retire each cycle.

Optional Feature:
- Macro: WB_DEBUG_TRACE_EN.
- Defined: adds outputs debug_wb_pc[32], debug_wb_rf_we[4], debug_wb_rf_wnum[5], debug_wb_rf_wdata[32]. The last three mirror the RF port; debug_wb_rf_we = {4{rf_we}}; debug_wb_pc = pc when ws_valid, else 0.
- Undefined: these ports and their logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset held 3 cycles with ms2ws_valid=1 -> all outputs 0, ws_allowin=1; first bus after release commits on the next cycle.
- ALU op pc=0x1C000010, dest=5, result=0xDEADBEEF, gr_we=1 -> rf_we=1, waddr=5, wdata=0xDEADBEEF for one cycle; dest=0 variant -> rf_we=0.
- csrxchg with csr_re=1, csr_we=1, csr_num=0x0, rkd=0x4, mask=0x7, csr_rvalue=0x8 -> rf_wdata=0x8, csr_wvalue=0x4, csr_wmask=0x7, ws_csr_block=1.
- Load with exc_ecode=0x08 (ADEM) and ecode=0x0B -> wb_ex=1, wb_ecode=0x08, esubcode=0, rf_we=0, ws_reflush=1; an instruction arriving that cycle is dropped (ws_valid=0 next cycle).
- tlbwr with refetch=1, pc=0x1C000100 -> tlbwr_we=1, refetch_flush=1, refetch_pc=0x1C000104; same instruction with ex=1 -> tlbwr_we=0, refetch_flush=0, wb_ex=1.
- ertn back-to-back with an add -> wb_ertn=1 and ws_reflush=1 for one cycle; the following add does not commit.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle and commits RF, CSR and TLB updates and flushes.
// Optional debug-trace outputs are compiled in when WB_DEBUG_TRACE_EN is defined.
module wb_stage #(
    parameter int MS2WS_BUS_LEN = 219,
    parameter int EXC_DATA_LEN  = 101
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ws_allowin,
    input  logic                     ms2ws_valid,
    input  logic [MS2WS_BUS_LEN-1:0] ms2ws_bus,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic [37:0]              wb_forward_zip,
    output logic                     ws_csr_block,
    output logic                     csr_re,
    output logic [13:0]              csr_num,
    input  logic [31:0]              csr_rvalue,
    output logic                     csr_we,
    output logic [31:0]              csr_wmask,
    output logic [31:0]              csr_wvalue,
    output logic                     wb_ex,
    output logic                     wb_ertn,
    output logic [5:0]               wb_ecode,
    output logic [8:0]               wb_esubcode,
    output logic [31:0]              wb_pc,
    output logic [31:0]              wb_vaddr,
    output logic                     tlbsrch_we,
    output logic                     tlbsrch_hit,
    output logic [3:0]               tlbsrch_index,
    output logic                     tlbrd_we,
    output logic                     tlbwr_we,
    output logic                     tlbfill_we,
    output logic                     ws_reflush,
    output logic                     refetch_flush,
    output logic [31:0]              refetch_pc
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_we,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata
`endif
);

    localparam int RKD_LSB    = EXC_DATA_LEN;
    localparam int RESULT_LSB = RKD_LSB + 32;
    localparam int DEST_LSB   = RESULT_LSB + 32;
    localparam int GRWE_BIT   = DEST_LSB + 5;
    localparam int PC_LSB     = GRWE_BIT + 1;
    localparam int SIDX_LSB   = PC_LSB + 32;
    localparam int SHIT_BIT   = SIDX_LSB + 4;
    localparam int FILL_BIT   = SHIT_BIT + 1;
    localparam int WR_BIT     = FILL_BIT + 1;
    localparam int RD_BIT     = WR_BIT + 1;
    localparam int SRCH_BIT   = RD_BIT + 1;
    localparam int REFE_BIT   = SRCH_BIT + 1;
    localparam int EXCE_LSB   = REFE_BIT + 1;

    logic                     ws_valid_q, ws_valid_d;
    logic [MS2WS_BUS_LEN-1:0] bus_q, bus_d;

    logic [5:0]  exc_ecode_f;
    logic        refetch_f;
    logic        tlbsrch_f;
    logic        tlbrd_f;
    logic        tlbwr_f;
    logic        tlbfill_f;
    logic        srch_hit_f;
    logic [3:0]  srch_index_f;
    logic [31:0] pc_f;
    logic        gr_we_f;
    logic [4:0]  dest_f;
    logic [31:0] result_f;
    logic [31:0] rkd_value_f;
    logic [3:0]  unused_csr_op;
    logic [31:0] vaddr_f;
    logic        csr_we_f;
    logic [31:0] csr_wmask_f;
    logic [13:0] csr_num_f;
    logic        ertn_f;
    logic        ex_f;
    logic [8:0]  esubcode_f;
    logic [5:0]  ecode_f;
    logic        csr_re_f;

    logic        exc;
    logic        commit;

    assign exc_ecode_f   = bus_q[EXCE_LSB +: 6];
    assign refetch_f     = bus_q[REFE_BIT];
    assign tlbsrch_f     = bus_q[SRCH_BIT];
    assign tlbrd_f       = bus_q[RD_BIT];
    assign tlbwr_f       = bus_q[WR_BIT];
    assign tlbfill_f     = bus_q[FILL_BIT];
    assign srch_hit_f    = bus_q[SHIT_BIT];
    assign srch_index_f  = bus_q[SIDX_LSB +: 4];
    assign pc_f          = bus_q[PC_LSB +: 32];
    assign gr_we_f       = bus_q[GRWE_BIT];
    assign dest_f        = bus_q[DEST_LSB +: 5];
    assign result_f      = bus_q[RESULT_LSB +: 32];
    assign rkd_value_f   = bus_q[RKD_LSB +: 32];

    // The csr_op field is carried on the bus but has no meaning in this stage.
    assign unused_csr_op = bus_q[100:97];
    assign vaddr_f       = bus_q[96:65];
    assign csr_we_f      = bus_q[64];
    assign csr_wmask_f   = bus_q[63:32];
    assign csr_num_f     = bus_q[31:18];
    assign ertn_f        = bus_q[17];
    assign ex_f          = bus_q[16];
    assign esubcode_f    = bus_q[15:7];
    assign ecode_f       = bus_q[6:1];
    assign csr_re_f      = bus_q[0];

    always_comb begin
        ws_valid_d = ms2ws_valid;
        bus_d      = bus_q;
        if (ws_reflush) begin
            ws_valid_d = 1'b0;
        end
        if (ms2ws_valid) begin
            bus_d = ms2ws_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            bus_q      <= bus_d;
        end
    end

    assign ws_allowin = 1'b1;

    assign exc    = ws_valid_q & ((exc_ecode_f != 6'd0) | ex_f);
    assign commit = ws_valid_q & ~exc;

    // Every informational output reads as zero whenever the stage is empty.
    assign wb_ex       = exc;
    assign wb_ertn     = commit & ertn_f;
    assign wb_ecode    = {6{ws_valid_q}} & ((exc_ecode_f != 6'd0) ? exc_ecode_f : ecode_f);
    assign wb_esubcode = {9{ws_valid_q}} & ((exc_ecode_f != 6'd0) ? 9'd0 : esubcode_f);
    assign wb_pc       = {32{ws_valid_q}} & pc_f;
    assign wb_vaddr    = {32{ws_valid_q}} & vaddr_f;

    assign rf_we    = commit & gr_we_f & (dest_f != 5'd0);
    assign rf_waddr = {5{ws_valid_q}} & dest_f;
    assign rf_wdata = {32{ws_valid_q}} & (csr_re_f ? csr_rvalue : result_f);

    assign wb_forward_zip = {rf_we, rf_waddr, rf_wdata};

    assign csr_re       = ws_valid_q & csr_re_f;
    assign csr_num      = {14{ws_valid_q}} & csr_num_f;
    assign csr_we       = commit & csr_we_f;
    assign csr_wmask    = {32{ws_valid_q}} & csr_wmask_f;
    assign csr_wvalue   = {32{ws_valid_q}} & rkd_value_f;
    assign ws_csr_block = ws_valid_q & (csr_re_f | csr_we_f | ertn_f);

    assign tlbsrch_we    = commit & tlbsrch_f;
    assign tlbsrch_hit   = ws_valid_q & srch_hit_f;
    assign tlbsrch_index = {4{ws_valid_q}} & srch_index_f;
    assign tlbrd_we      = commit & tlbrd_f;
    assign tlbwr_we      = commit & tlbwr_f;
    assign tlbfill_we    = commit & tlbfill_f;

    // Refetch restarts at the next sequential instruction; the add wraps at 2^32.
    assign refetch_flush = commit & refetch_f;
    assign refetch_pc    = {32{ws_valid_q}} & (pc_f + 32'd4);
    assign ws_reflush    = wb_ex | wb_ertn | refetch_flush;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = {32{ws_valid_q}} & pc_f;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed instructions push hand-computed expectations,
// a negedge monitor pops and compares them one cycle after each handoff.
module tb_wb_stage;

    typedef struct packed {
        logic [5:0]  exc_ecode;
        logic        refetch;
        logic        tlbsrch;
        logic        tlbrd;
        logic        tlbwr;
        logic        tlbfill;
        logic        srch_hit;
        logic [3:0]  srch_index;
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] rkd;
        logic [3:0]  csr_op;
        logic [31:0] vaddr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [13:0] csr_num;
        logic        ertn;
        logic        ex;
        logic [8:0]  esubcode;
        logic [5:0]  ecode;
        logic        csr_re;
    } in_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_re;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        block;
        logic        ex;
        logic        ertn;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic        srch_we;
        logic        srch_hit;
        logic [3:0]  srch_idx;
        logic        rd;
        logic        wr;
        logic        fill;
        logic        reflush;
        logic        rflush;
        logic [31:0] rpc;
    } out_t;

    typedef struct {
        int   due;
        out_t exp;
    } sb_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms2ws_valid;
    logic [218:0] ms2ws_bus;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [37:0]  wb_forward_zip;
    logic         ws_csr_block;
    logic         csr_re;
    logic [13:0]  csr_num;
    logic [31:0]  csr_rvalue;
    logic         csr_we;
    logic [31:0]  csr_wmask;
    logic [31:0]  csr_wvalue;
    logic         wb_ex;
    logic         wb_ertn;
    logic [5:0]   wb_ecode;
    logic [8:0]   wb_esubcode;
    logic [31:0]  wb_pc;
    logic [31:0]  wb_vaddr;
    logic         tlbsrch_we;
    logic         tlbsrch_hit;
    logic [3:0]   tlbsrch_index;
    logic         tlbrd_we;
    logic         tlbwr_we;
    logic         tlbfill_we;
    logic         ws_reflush;
    logic         refetch_flush;
    logic [31:0]  refetch_pc;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;
`endif

    int  cyc = 0;
    int  checkCount = 0;
    int  passCount = 0;
    sb_t sbQ[$];

    wb_stage dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
        .ms2ws_valid(ms2ws_valid), .ms2ws_bus(ms2ws_bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_forward_zip(wb_forward_zip), .ws_csr_block(ws_csr_block),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ertn(wb_ertn), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .tlbsrch_we(tlbsrch_we), .tlbsrch_hit(tlbsrch_hit), .tlbsrch_index(tlbsrch_index),
        .tlbrd_we(tlbrd_we), .tlbwr_we(tlbwr_we), .tlbfill_we(tlbfill_we),
        .ws_reflush(ws_reflush), .refetch_flush(refetch_flush), .refetch_pc(refetch_pc)
`ifdef WB_DEBUG_TRACE_EN
        ,
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Stimulus only pushes expectations; the result appears after the next rising edge.
    task automatic applyStimulus(input logic v, input in_t b, input out_t e);
        sb_t s;
        ms2ws_valid = v;
        ms2ws_bus   = b;
        s.due = cyc + 1;
        s.exp = e;
        sbQ.push_back(s);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sbQ.size() > 0 && sbQ[0].due < cyc) begin
            checkOutput("missed", 128'(sbQ[0].due), 128'(cyc));
            void'(sbQ.pop_front());
        end
        if (sbQ.size() > 0 && sbQ[0].due == cyc) begin
            sb_t s;
            s = sbQ.pop_front();
            checkOutput("allowin", 128'(ws_allowin), 128'(1'b1));
            checkOutput("rf", 128'({rf_we, rf_waddr, rf_wdata}),
                        128'({s.exp.rf_we, s.exp.waddr, s.exp.wdata}));
            checkOutput("fwd", 128'(wb_forward_zip),
                        128'({s.exp.rf_we, s.exp.waddr, s.exp.wdata}));
            checkOutput("csr", 128'({csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, ws_csr_block}),
                        128'({s.exp.csr_re, s.exp.csr_num, s.exp.csr_we, s.exp.wmask,
                              s.exp.wvalue, s.exp.block}));
            checkOutput("exc", 128'({wb_ex, wb_ertn, wb_ecode, wb_esubcode}),
                        128'({s.exp.ex, s.exp.ertn, s.exp.ecode, s.exp.esub}));
            checkOutput("excinfo", 128'({wb_pc, wb_vaddr}), 128'({s.exp.pc, s.exp.vaddr}));
            checkOutput("tlb", 128'({tlbsrch_we, tlbsrch_hit, tlbsrch_index, tlbrd_we, tlbwr_we, tlbfill_we}),
                        128'({s.exp.srch_we, s.exp.srch_hit, s.exp.srch_idx, s.exp.rd,
                              s.exp.wr, s.exp.fill}));
            checkOutput("flush", 128'({ws_reflush, refetch_flush, refetch_pc}),
                        128'({s.exp.reflush, s.exp.rflush, s.exp.rpc}));
`ifdef WB_DEBUG_TRACE_EN
            checkOutput("dbg", 128'({debug_wb_pc, debug_wb_rf_we}),
                        128'({s.exp.pc, {4{s.exp.rf_we}}}));
`endif
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_t  alu, b;
        out_t eAlu, e, zero;
        zero = '0;

        alu = '0;
        alu.pc = 32'h1C000010; alu.gr_we = 1'b1; alu.dest = 5'd5; alu.result = 32'hDEADBEEF;
        eAlu = '0;
        eAlu.rf_we = 1'b1; eAlu.waddr = 5'd5; eAlu.wdata = 32'hDEADBEEF;
        eAlu.pc = 32'h1C000010; eAlu.rpc = 32'h1C000014;

        reset = 1'b1;
        csr_rvalue = 32'h00000008;
        ms2ws_valid = 1'b0;
        ms2ws_bus = '0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, alu, zero);
        reset = 1'b0;

        applyStimulus(1'b1, alu, eAlu);

        b = '0; b.pc = 32'h1C000014; b.gr_we = 1'b1; b.dest = 5'd0; b.result = 32'h12345678;
        e = '0; e.waddr = 5'd0; e.wdata = 32'h12345678; e.pc = 32'h1C000014; e.rpc = 32'h1C000018;
        applyStimulus(1'b1, b, e);

        b = '0; b.pc = 32'h1C000020; b.gr_we = 1'b1; b.dest = 5'd4; b.result = 32'h55;
        b.csr_re = 1'b1; b.csr_we = 1'b1; b.csr_num = 14'h0; b.rkd = 32'h4; b.csr_wmask = 32'h7;
        e = '0; e.rf_we = 1'b1; e.waddr = 5'd4; e.wdata = 32'h8; e.csr_re = 1'b1; e.csr_we = 1'b1;
        e.wmask = 32'h7; e.wvalue = 32'h4; e.block = 1'b1; e.pc = 32'h1C000020; e.rpc = 32'h1C000024;
        applyStimulus(1'b1, b, e);

        b = '0; b.pc = 32'h1C000030; b.gr_we = 1'b1; b.dest = 5'd6; b.result = 32'h99;
        b.exc_ecode = 6'h08; b.ecode = 6'h0B; b.esubcode = 9'h1; b.vaddr = 32'h3;
        e = '0; e.waddr = 5'd6; e.wdata = 32'h99; e.ex = 1'b1; e.ecode = 6'h08; e.esub = 9'h0;
        e.pc = 32'h1C000030; e.vaddr = 32'h3; e.reflush = 1'b1; e.rpc = 32'h1C000034;
        applyStimulus(1'b1, b, e);
        b = alu; b.pc = 32'h1C000034;
        applyStimulus(1'b1, b, zero);
        applyStimulus(1'b1, alu, eAlu);

        b = '0; b.pc = 32'h1C000100; b.tlbwr = 1'b1; b.refetch = 1'b1;
        e = '0; e.wr = 1'b1; e.rflush = 1'b1; e.reflush = 1'b1; e.pc = 32'h1C000100; e.rpc = 32'h1C000104;
        applyStimulus(1'b1, b, e);
        applyStimulus(1'b0, alu, zero);

        b.ex = 1'b1; b.ecode = 6'h0D; b.esubcode = 9'h5;
        e = '0; e.ex = 1'b1; e.ecode = 6'h0D; e.esub = 9'h5; e.reflush = 1'b1;
        e.pc = 32'h1C000100; e.rpc = 32'h1C000104;
        applyStimulus(1'b1, b, e);
        applyStimulus(1'b0, alu, zero);

        b = '0; b.pc = 32'h1C000200; b.tlbsrch = 1'b1; b.srch_hit = 1'b1; b.srch_index = 4'hA;
        e = '0; e.srch_we = 1'b1; e.srch_hit = 1'b1; e.srch_idx = 4'hA;
        e.pc = 32'h1C000200; e.rpc = 32'h1C000204;
        applyStimulus(1'b1, b, e);

        b = '0; b.pc = 32'h1C000210; b.tlbrd = 1'b1;
        e = '0; e.rd = 1'b1; e.pc = 32'h1C000210; e.rpc = 32'h1C000214;
        applyStimulus(1'b1, b, e);

        b = '0; b.pc = 32'hFFFFFFFC; b.tlbfill = 1'b1; b.refetch = 1'b1;
        e = '0; e.fill = 1'b1; e.rflush = 1'b1; e.reflush = 1'b1; e.pc = 32'hFFFFFFFC; e.rpc = 32'h0;
        applyStimulus(1'b1, b, e);
        applyStimulus(1'b0, alu, zero);

        b = '0; b.pc = 32'h1C000300; b.ertn = 1'b1;
        e = '0; e.ertn = 1'b1; e.block = 1'b1; e.reflush = 1'b1; e.pc = 32'h1C000300; e.rpc = 32'h1C000304;
        applyStimulus(1'b1, b, e);
        b = '0; b.pc = 32'h1C000304; b.gr_we = 1'b1; b.dest = 5'd7; b.result = 32'h1;
        applyStimulus(1'b1, b, zero);
        b = '0; b.pc = 32'h1C000308; b.gr_we = 1'b1; b.dest = 5'd8; b.result = 32'hCAFE0001;
        e = '0; e.rf_we = 1'b1; e.waddr = 5'd8; e.wdata = 32'hCAFE0001;
        e.pc = 32'h1C000308; e.rpc = 32'h1C00030C;
        applyStimulus(1'b1, b, e);

        b = '0; b.pc = 32'h1C000400; b.ertn = 1'b1; b.ex = 1'b1; b.ecode = 6'h0C;
        e = '0; e.ex = 1'b1; e.ecode = 6'h0C; e.block = 1'b1; e.reflush = 1'b1;
        e.pc = 32'h1C000400; e.rpc = 32'h1C000404;
        applyStimulus(1'b1, b, e);
        applyStimulus(1'b0, alu, zero);

        for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(posedge clk);
        if (sbQ.size() > 0) begin
            checkOutput("drain", 128'(sbQ.size()), 128'(0));
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
